// File: rtl/core_pkg.sv
// Shared types and widths for the fetch stage.
package core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_pkt_t;

  // Word-align a byte address by clearing the low two bits.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(32'h3);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry fetch packet buffer; flush wins over push and pop.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t data_in,
  output fetch_pkt_t data_out,
  output logic       full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      data_out <= '0;
    end else if (flush) begin
      full     <= 1'b0;
    end else if (push) begin
      full     <= 1'b1;
      data_out <= data_in;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC ownership, single-outstanding imem request, skid-buffered handoff to decode.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            squash_q, squash_d;
  fetch_pkt_t      out_q, out_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            skid_push, skid_pop, skid_flush, skid_full;
  fetch_pkt_t      skid_pkt, resp_pkt;
  logic            consume, granted;

  assign consume  = valid_q && !stall_i;
  assign granted  = req_q && imem_gnt_i;
  assign resp_pkt = '{instr: imem_rdata_i, pc: req_pc_q};

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (skid_push),
    .pop      (skid_pop),
    .flush    (skid_flush),
    .data_in  (resp_pkt),
    .data_out (skid_pkt),
    .full     (skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= REQ;
    else     state_q <= state_d;
  end

  // Next state plus all datapath next values; redirect overrides stall and normal sequencing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    squash_d   = squash_q;
    out_d      = out_q;
    valid_d    = valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;

    if (redirect_i) begin
      pc_d       = word_align(redirect_pc_i);
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      unique case (state_q)
        REQ: begin
          if (granted) begin
            squash_d = 1'b1;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            squash_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end else begin
      // Decode took the current word: refill from skid or go empty.
      if (consume) begin
        if (skid_full) begin
          out_d    = skid_pkt;
          skid_pop = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end

      unique case (state_q)
        REQ: begin
          if (granted) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = REQ;
            end else if ((!valid_q || consume) && !skid_full) begin
              out_d   = resp_pkt;
              valid_d = 1'b1;
              state_d = REQ;
            end else begin
              skid_push = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!skid_full) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  assign req_d  = (state_d == REQ);
  assign addr_d = pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      squash_q <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      squash_q <= squash_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = out_q.instr;
  assign pc_o          = out_q.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, latency, grant stall, skid, redirect, async reset, PC wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks req/addr/valid in one call; instr/pc checked separately where relevant.
  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr, input logic vld);
    chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
    if (req) chk({tag, "_addr"}, imem_addr_o, addr);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, {31'd0, vld});
  endtask

  initial begin
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    stall_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();

    // Reset state
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h100);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);

    // First fetch: grant as soon as the request is up, respond next cycle
    rst = 1'b0; imem_gnt_i = 1'b1;
    tick();
    chk_bus("first_req", 1'b1, 32'h100, 1'b0);
    tick();
    chk_bus("first_wait", 1'b0, 32'h0, 1'b0);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("first_dlv", 1'b1, 32'h104, 1'b1);
    chk("first_instr", instr_o, 32'h0050_0093);
    chk("first_pc", pc_o, 32'h100);

    // Delayed grant: address holds for three ungranted cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bus("nogrant", 1'b1, 32'h104, 1'b1);
      chk("nogrant_instr", instr_o, 32'h0050_0093);
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    chk_bus("grant2", 1'b0, 32'h0, 1'b1);

    // Response under stall lands in the skid
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("skid_in", 1'b0, 32'h0, 1'b1);
    chk("skid_hold_instr", instr_o, 32'h0050_0093);
    chk("skid_hold_pc", pc_o, 32'h100);
    tick();
    chk_bus("skid_stay", 1'b0, 32'h0, 1'b1);
    chk("skid_stay_instr", instr_o, 32'h0050_0093);
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    chk_bus("skid_drain", 1'b0, 32'h0, 1'b1);
    chk("skid_drain_instr", instr_o, 32'h00A0_0113);
    chk("skid_drain_pc", pc_o, 32'h104);
    tick();
    chk_bus("after_drain", 1'b1, 32'h108, 1'b1);

    // Redirect while waiting: outstanding response is squashed
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    chk_bus("redir_wait", 1'b0, 32'h0, 1'b0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("redir_squash", 1'b1, 32'h200, 1'b0);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("redir_dlv", 1'b1, 32'h204, 1'b1);
    chk("redir_instr", instr_o, 32'h0000_0013);
    chk("redir_pc", pc_o, 32'h200);

    // Redirect beats stall with a full skid
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("rs_skid", 1'b0, 32'h0, 1'b1);
    chk("rs_skid_instr", instr_o, 32'h0000_0013);
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    tick();
    redirect_i = 1'b0;
    chk_bus("rs_redir", 1'b1, 32'h400, 1'b0);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("rs_dlv", 1'b1, 32'h404, 1'b1);
    chk("rs_instr", instr_o, 32'h2222_2222);
    chk("rs_pc", pc_o, 32'h400);

    // Asynchronous reset in WAIT, then a stale rvalid after release
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_addr", imem_addr_o, 32'h100);
    #2 rst = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("stale", 1'b1, 32'h100, 1'b0);
    tick();
    chk_bus("stale2", 1'b1, 32'h100, 1'b0);

    // PC wrap: redirect in REQ to the top word (low bits ignored)
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    chk_bus("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_4444;
    tick();
    imem_rvalid_i = 1'b0;
    chk_bus("wrap_dlv", 1'b1, 32'h0, 1'b1);
    chk("wrap_instr", instr_o, 32'h4444_4444);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);

    // Consume without a successor empties the output
    stall_i = 1'b0;
    tick();
    chk_bus("consume", 1'b1, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
